// File: rtl/instr_issue_queue.sv
// In-order instruction issue queue: DEPTH-entry FIFO feeding N_ENG matmul engines with
// per-engine in-flight tracking and RAW/WAW hazard stalls. Optional counters: INSTQ_PERF_CNT_EN.

package common_pkg;
    typedef logic [7:0] addr_t;

    typedef enum logic {
        MMUL_D  = 1'b0,
        MMUL_ND = 1'b1
    } op_t;

    typedef struct packed {
        op_t   op;
        addr_t dest;
        addr_t src1;
        addr_t src2;
    } instruction_t;
endpackage

module instr_issue_queue
    import common_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int N_ENG = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  instruction_t                    in_inst,
    input  logic                            in_valid,
    output logic                            in_ready,
    output instruction_t [N_ENG-1:0]        out_inst,
    output logic [N_ENG-1:0]                out_valid,
    input  logic [N_ENG-1:0]                out_ready,
    input  logic [N_ENG-1:0]                eng_done,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            empty
`ifdef INSTQ_PERF_CNT_EN
    ,
    output logic [31:0]                     issued_cnt,
    output logic [31:0]                     hz_stall_cnt,
    output logic [31:0]                     eng_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENG_W = (N_ENG > 1) ? $clog2(N_ENG) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    instruction_t             r_mem [DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;
    logic [ENG_W-1:0]         r_rr;
    logic [N_ENG-1:0]         r_busy;
    addr_t                    r_bdest [N_ENG];
    instruction_t [N_ENG-1:0] r_out_inst;
    logic [N_ENG-1:0]         r_out_valid;

    instruction_t             w_head;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_hazard;
    logic                     w_any_free;
    logic [ENG_W-1:0]         w_sel;
    logic [ENG_W-1:0]         w_rr_next;
    logic                     w_issue;
    logic [N_ENG-1:0]         w_issue_vec;

    assign w_empty  = (r_count == '0);
    assign in_ready = (r_count != FULL_CNT);
    assign w_push   = in_valid && in_ready;
    assign w_head   = r_mem[r_rd_ptr];

    // NOTE: every variable driven in always_comb gets a default first, so no path leaves it
    // holding its old value and no latch is inferred.
    always_comb begin
        w_hazard = 1'b0;
        for (int e = 0; e < N_ENG; e++) begin
            if (r_busy[e] && (r_bdest[e] == w_head.src1 || r_bdest[e] == w_head.src2 ||
                              r_bdest[e] == w_head.dest)) begin
                w_hazard = 1'b1;
            end
        end
    end

    // Round-robin: first idle engine at or after r_rr, then wrap to the ones below it.
    always_comb begin
        w_any_free = 1'b0;
        w_sel      = '0;
        for (int e = 0; e < N_ENG; e++) begin
            if (!w_any_free && !r_busy[e] && e >= int'(r_rr)) begin
                w_any_free = 1'b1;
                w_sel      = ENG_W'(e);
            end
        end
        for (int e = 0; e < N_ENG; e++) begin
            if (!w_any_free && !r_busy[e] && e < int'(r_rr)) begin
                w_any_free = 1'b1;
                w_sel      = ENG_W'(e);
            end
        end
    end

    always_comb begin
        w_rr_next = '0;
        if (int'(w_sel) != N_ENG - 1) begin
            w_rr_next = w_sel + ENG_W'(1);
        end
    end

    assign w_issue = !w_empty && !w_hazard && w_any_free;

    always_comb begin
        w_issue_vec = '0;
        for (int e = 0; e < N_ENG; e++) begin
            w_issue_vec[e] = w_issue && (int'(w_sel) == e);
        end
    end

    // NOTE: the storage array has no reset; the pointers and count define which entries are
    // meaningful, so clearing the data would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_inst;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rr        <= '0;
            r_busy      <= '0;
            r_out_inst  <= '0;
            r_out_valid <= '0;
            for (int e = 0; e < N_ENG; e++) begin
                r_bdest[e] <= '0;
            end
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_rr     <= w_rr_next;
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // An issuing engine is idle by construction, so issue and release never collide.
            for (int e = 0; e < N_ENG; e++) begin
                if (w_issue_vec[e]) begin
                    r_out_inst[e]  <= w_head;
                    r_out_valid[e] <= 1'b1;
                    r_busy[e]      <= 1'b1;
                    r_bdest[e]     <= w_head.dest;
                end else begin
                    if (out_ready[e]) begin
                        r_out_valid[e] <= 1'b0;
                    end
                    if (eng_done[e]) begin
                        r_busy[e] <= 1'b0;
                    end
                end
            end
        end
    end

    assign out_inst  = r_out_inst;
    assign out_valid = r_out_valid;
    assign count     = r_count;
    assign empty     = w_empty;

`ifdef INSTQ_PERF_CNT_EN
    logic        w_hz_stall;
    logic        w_eng_stall;
    logic [31:0] r_issued_cnt;
    logic [31:0] r_hz_stall_cnt;
    logic [31:0] r_eng_stall_cnt;

    assign w_hz_stall  = !w_empty && w_hazard;
    assign w_eng_stall = !w_empty && !w_hazard && !w_any_free;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_issued_cnt    <= '0;
            r_hz_stall_cnt  <= '0;
            r_eng_stall_cnt <= '0;
        end else begin
            if (w_issue && r_issued_cnt != '1) begin
                r_issued_cnt <= r_issued_cnt + 32'd1;
            end
            if (w_hz_stall && r_hz_stall_cnt != '1) begin
                r_hz_stall_cnt <= r_hz_stall_cnt + 32'd1;
            end
            if (w_eng_stall && r_eng_stall_cnt != '1) begin
                r_eng_stall_cnt <= r_eng_stall_cnt + 32'd1;
            end
        end
    end

    assign issued_cnt    = r_issued_cnt;
    assign hz_stall_cnt  = r_hz_stall_cnt;
    assign eng_stall_cnt = r_eng_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed self-checking bench for instr_issue_queue (DEPTH=8, N_ENG=2); expected values are
// hand-derived cycle by cycle from the queue's issue rules.

module tb_instr_issue_queue;
    import common_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset;
    instruction_t             in_inst;
    logic                     in_valid;
    logic                     in_ready;
    instruction_t [1:0]       out_inst;
    logic [1:0]               out_valid;
    logic [1:0]               out_ready;
    logic [1:0]               eng_done;
    logic [3:0]               count;
    logic                     empty;
`ifdef INSTQ_PERF_CNT_EN
    logic [31:0]              issued_cnt;
    logic [31:0]              hz_stall_cnt;
    logic [31:0]              eng_stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int tmr [2];
    int eng_q [$];
    int dst_q [$];
    int exp_eng [4] = '{0, 1, 0, 1};

    instruction_t ia, ib, ix, iy, iz, in6;

    instr_issue_queue #(.DEPTH(8), .N_ENG(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_inst   (in_inst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_inst  (out_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .eng_done  (eng_done),
        .count     (count),
        .empty     (empty)
`ifdef INSTQ_PERF_CNT_EN
        ,
        .issued_cnt    (issued_cnt),
        .hz_stall_cnt  (hz_stall_cnt),
        .eng_stall_cnt (eng_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input instruction_t inst);
        in_inst  = inst;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input logic [1:0] rdy);
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_inst   = '0;
        eng_done  = '0;
        out_ready = rdy;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic instruction_t mk(input op_t op, input int d, input int s1, input int s2);
        instruction_t t;
        t.op   = op;
        t.dest = 8'(d);
        t.src1 = 8'(s1);
        t.src2 = 8'(s2);
        return t;
    endfunction

    initial begin
        // Reset state, then single-instruction latency.
        do_reset(2'b11);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_inst", out_inst, 0);
        ia = mk(MMUL_ND, 'h10, 'h01, 'h02);
        push(ia);
        check("t1_acc_count", count, 1);
        check("t1_acc_valid", out_valid, 0);
        tick();
        check("t1_iss_valid", out_valid, 2'b01);
        check("t1_iss_inst", out_inst[0], ia);
        check("t1_iss_empty", empty, 1);
        tick();
        check("t1_valid_drop", out_valid, 0);

        // Fill: two engines busy, eight more queued, the eleventh push refused.
        do_reset(2'b11);
        for (int i = 0; i < 10; i++) begin
            in_inst  = mk(op_t'(i % 2), 'h40 + i, 'h80 + i, 'hA0 + i);
            in_valid = 1'b1;
            tick();
        end
        check("t2_full_ready", in_ready, 0);
        check("t2_full_count", count, 8);
        in_inst = mk(MMUL_D, 'h4A, 'h8A, 'hAA);
        tick();
        in_valid = 1'b0;
        check("t2_drop_count", count, 8);
        check("t2_no_issue", out_valid, 0);
        eng_done = 2'b11;
        tick();
        eng_done = 2'b00;
        check("t2_release_valid", out_valid, 0);
        tick();
        check("t2_i2_valid", out_valid, 2'b01);
        check("t2_i2_inst", out_inst[0], mk(MMUL_D, 'h42, 'h82, 'hA2));
        check("t2_i2_count", count, 7);
        tick();
        check("t2_i3_valid", out_valid, 2'b10);
        check("t2_i3_inst", out_inst[1], mk(MMUL_ND, 'h43, 'h83, 'hA3));
        check("t2_i3_count", count, 6);

        // RAW hazard: B reads A's destination and waits for A's eng_done.
        do_reset(2'b11);
        ia = mk(MMUL_D, 'h20, 'h01, 'h02);
        ib = mk(MMUL_ND, 'h21, 'h20, 'h03);
        push(ia);
        push(ib);
        check("t3_a_valid", out_valid, 2'b01);
        check("t3_a_inst", out_inst[0], ia);
        tick();
        tick();
        tick();
        check("t3_stall_valid", out_valid, 0);
        check("t3_stall_count", count, 1);
        eng_done = 2'b01;
        tick();
        eng_done = 2'b00;
        check("t3_done_no_reuse", out_valid, 0);
        tick();
        check("t3_b_valid", out_valid, 2'b10);
        check("t3_b_inst", out_inst[1], ib);
        check("t3_b_count", count, 0);

        // Round-robin over four independent instructions, each engine done 3 cycles after issue.
        do_reset(2'b11);
        tmr[0] = 0;
        tmr[1] = 0;
        for (int cyc = 0; cyc < 40 && eng_q.size() < 4; cyc++) begin
            in_valid = (cyc < 4);
            in_inst  = mk(MMUL_D, 'h70 + cyc, 'h78 + cyc, 'h7C + cyc);
            tick();
            eng_done = 2'b00;
            for (int e = 0; e < 2; e++) begin
                if (tmr[e] > 0) begin
                    tmr[e]--;
                    if (tmr[e] == 0) eng_done[e] = 1'b1;
                end
            end
            for (int e = 0; e < 2; e++) begin
                if (out_valid[e]) begin
                    eng_q.push_back(e);
                    dst_q.push_back(int'(out_inst[e].dest));
                    tmr[e] = 2;
                end
            end
        end
        in_valid = 1'b0;
        eng_done = 2'b00;
        check("t4_issue_cnt", eng_q.size(), 4);
        for (int i = 0; i < eng_q.size() && i < 4; i++) begin
            check($sformatf("t4_eng_%0d", i), eng_q[i], exp_eng[i]);
            check($sformatf("t4_dest_%0d", i), dst_q[i], 'h70 + i);
        end

        // Backpressure hold, eng_done on an idle engine, done+ready together.
        do_reset(2'b00);
        ix = mk(MMUL_D, 'h50, 'h60, 'h61);
        iy = mk(MMUL_ND, 'h52, 'h62, 'h63);
        iz = mk(MMUL_D, 'h50, 'h64, 'h65);
        push(ix);
        tick();
        for (int h = 0; h < 5; h++) begin
            check($sformatf("t5_hold_valid_%0d", h), out_valid, 2'b01);
            check($sformatf("t5_hold_inst_%0d", h), out_inst[0], ix);
            eng_done = (h == 1) ? 2'b10 : 2'b00;
            tick();
        end
        eng_done = 2'b00;
        push(iy);
        tick();
        check("t5_y_valid", out_valid, 2'b11);
        check("t5_y_inst", out_inst[1], iy);
        check("t5_x_stable", out_inst[0], ix);
        out_ready = 2'b01;
        eng_done  = 2'b01;
        tick();
        eng_done = 2'b00;
        check("t5_ready_done_valid", out_valid, 2'b10);
        push(iz);
        tick();
        check("t5_z_valid", out_valid, 2'b11);
        check("t5_z_inst", out_inst[0], iz);

        // Reset mid-operation with three queued and both engines busy.
        do_reset(2'b00);
        for (int i = 0; i < 5; i++) begin
            push(mk(MMUL_D, 'h30 + i, 'h38 + i, 'h3C + i));
        end
        check("t6_pre_count", count, 3);
        check("t6_pre_valid", out_valid, 2'b11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_count", count, 0);
        check("t6_valid", out_valid, 0);
        check("t6_in_ready", in_ready, 1);
        check("t6_empty", empty, 1);
        check("t6_inst", out_inst[0], 0);
        in6 = mk(MMUL_ND, 'h30, 'h31, 'h32);
        push(in6);
        tick();
        check("t6_post_valid", out_valid, 2'b01);
        check("t6_post_inst", out_inst[0], in6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
